// File: rtl/aes_arb_pkg.sv
// Shared state encoding, defaults and width helper for the AES request arbiter.
package aes_arb_pkg;

    localparam int unsigned NREQ_DEFAULT    = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned BLOCK_W         = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    // Index width for a set of n items; never narrower than one bit.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_rr_picker.sv
// Round-robin search: first set request bit strictly after last_grant, wrapping.
module aes_rr_picker
    import aes_arb_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned IW   = grant_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            any,
    output logic [IW-1:0]   index
);

    int unsigned cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        any   = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned off = NREQ; off >= 1; off--) begin
            cand = 32'(last_grant) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[IW'(cand)]) begin
                any   = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES cipher core among NREQ requesters: round-robin accept, load,
// wait for the core (with timeout) and hold the response until it is taken.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int unsigned NREQ    = NREQ_DEFAULT,
    parameter  int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned IW      = grant_w(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][BLOCK_W-1:0] req_text,
    input  logic [NREQ-1:0][BLOCK_W-1:0] req_key,
    output logic [NREQ-1:0]              rsp_valid,
    input  logic [NREQ-1:0]              rsp_ready,
    output logic [BLOCK_W-1:0]           rsp_text,
    output logic                         rsp_err,
    output logic                         core_ld,
    output logic [BLOCK_W-1:0]           core_key,
    output logic [BLOCK_W-1:0]           core_text,
    input  logic                         core_done,
    input  logic [BLOCK_W-1:0]           core_text_out,
    output logic                         busy,
    output logic [IW-1:0]                grant_id
);

    localparam int unsigned     TW         = grant_w(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);

    arb_state_e         state, state_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [IW-1:0]      last_grant, last_grant_nxt;
    logic [IW-1:0]      grant_id_nxt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               core_ld_nxt;
    logic [BLOCK_W-1:0] core_key_nxt, core_text_nxt;
    logic [NREQ-1:0]    rsp_valid_nxt;
    logic [BLOCK_W-1:0] rsp_text_nxt;
    logic               rsp_err_nxt;
    logic               busy_nxt;

    aes_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .index      (pick_idx)
    );

    // State and registered outputs; core_key/core_text double as the request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            last_grant <= IW'(NREQ - 1);
            grant_id   <= '0;
            core_ld    <= 1'b0;
            core_key   <= '0;
            core_text  <= '0;
            rsp_valid  <= '0;
            rsp_text   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_id_nxt;
            core_ld    <= core_ld_nxt;
            core_key   <= core_key_nxt;
            core_text  <= core_text_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_text   <= rsp_text_nxt;
            rsp_err    <= rsp_err_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and output decode; req_ready is the only combinational output.
    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        last_grant_nxt = last_grant;
        grant_id_nxt   = grant_id;
        core_ld_nxt    = 1'b0;
        core_key_nxt   = core_key;
        core_text_nxt  = core_text;
        rsp_valid_nxt  = rsp_valid;
        rsp_text_nxt   = rsp_text;
        rsp_err_nxt    = rsp_err;
        busy_nxt       = busy;
        req_ready      = '0;

        unique case (state)
            ST_IDLE: begin
                if (pick_any && !rst) begin
                    req_ready     = ONE_HOT0 << pick_idx;
                    core_key_nxt  = req_key[pick_idx];
                    core_text_nxt = req_text[pick_idx];
                    grant_id_nxt  = pick_idx;
                    core_ld_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    state_nxt     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (core_done) begin
                    rsp_text_nxt  = core_text_out;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = ONE_HOT0 << grant_id;
                    state_nxt     = ST_RESP;
                end else if (timer == TIMER_LAST) begin
                    rsp_text_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = ONE_HOT0 << grant_id;
                    state_nxt     = ST_RESP;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ST_RESP: begin
                if (|(rsp_ready & rsp_valid)) begin
                    rsp_valid_nxt  = '0;
                    last_grant_nxt = grant_id;
                    busy_nxt       = 1'b0;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed plus randomized bench for aes_req_arbiter with a latency-programmable
// core model and a transaction-level round-robin reference.
module tb_aes_req_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 64;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][127:0] req_text;
    logic [N-1:0][127:0] req_key;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [127:0]        rsp_text;
    logic                rsp_err;
    logic                core_ld;
    logic [127:0]        core_key;
    logic [127:0]        core_text;
    logic                core_done = 1'b0;
    logic [127:0]        core_text_out = '0;
    logic                busy;
    logic [1:0]          grant_id;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int           core_lat  = 1;
    bit           core_mute = 1'b0;
    bit           stray     = 1'b0;
    int           core_rem  = 0;
    bit           core_pend = 1'b0;
    logic [127:0] core_k    = '0;
    logic [127:0] core_t    = '0;

    bit [N-1:0]   pend;
    logic [127:0] mkey  [N];
    logic [127:0] mtext [N];
    int           model_last;

    aes_req_arbiter #(
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_text      (req_text),
        .req_key       (req_key),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_text      (rsp_text),
        .rsp_err       (rsp_err),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text     (core_text),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    // Stand-in cipher: known-answer vector, otherwise a cheap invertible mix.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
        if (k == KAT_KEY && t == KAT_PT) return KAT_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_0123_4567_89ab_cdef;
    endfunction

    // Core model: core_done lands core_lat cycles after the core_ld cycle.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        core_done <= stray;
        if (core_ld && !core_mute) begin
            core_k <= core_key;
            core_t <= core_text;
            if (core_lat <= 1) begin
                core_done     <= 1'b1;
                core_text_out <= cipher(core_key, core_text);
                core_pend     <= 1'b0;
            end else begin
                core_rem  <= core_lat - 1;
                core_pend <= 1'b1;
            end
        end else if (core_pend) begin
            if (core_rem == 1) begin
                core_done     <= 1'b1;
                core_text_out <= cipher(core_k, core_t);
                core_pend     <= 1'b0;
            end
            core_rem <= core_rem - 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req_key[i]  = mkey[i];
            req_text[i] = mtext[i];
        end
        req_valid = pend;
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] t);
        mkey[i]  = k;
        mtext[i] = t;
        pend[i]  = 1'b1;
    endtask

    task automatic new_req(input int i);
        set_req(i, {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom});
    endtask

    // Reference arbitration: nearest pending requester after the last one served.
    function automatic int model_pick();
        for (int k = 1; k <= N; k++) begin
            if (pend[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string ph);
        chk({ph, "_req_ready"}, 128'(req_ready), '0);
        chk({ph, "_rsp_valid"}, 128'(rsp_valid), '0);
        chk({ph, "_rsp_text"},  rsp_text,        '0);
        chk({ph, "_rsp_err"},   128'(rsp_err),   '0);
        chk({ph, "_core_ld"},   128'(core_ld),   '0);
        chk({ph, "_core_key"},  core_key,        '0);
        chk({ph, "_core_text"}, core_text,       '0);
        chk({ph, "_busy"},      128'(busy),      '0);
        chk({ph, "_grant_id"},  128'(grant_id),  '0);
    endtask

    // One full transaction against the reference: accept, load, wait, respond.
    task automatic serve_one(input int lat, input bit mute, input int bp,
                             input bit refill, input bit glitch, output int acc_cyc);
        int           g, n, lds, gl, elat;
        bit           eerr;
        logic [127:0] ek, et, ert;
        core_lat  = lat;
        core_mute = mute;
        g = model_pick();
        if (g < 0) begin
            new_req(0);
            g = 0;
        end
        gl = (g + 1) % N;
        ek = mkey[g];
        et = mtext[g];
        drive_req();
        n = 0;
        while (req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready", 128'(req_ready), 128'(onehot(g)));
        acc_cyc = cyc;
        tick();
        if (refill) new_req(g);
        else pend[g] = 1'b0;
        drive_req();
        chk("grant_id",  128'(grant_id), 128'(g));
        chk("core_ld",   128'(core_ld),  128'(1));
        chk("core_key",  core_key,       ek);
        chk("core_text", core_text,      et);
        chk("busy",      128'(busy),     128'(1));
        tick();
        chk("core_ld_once", 128'(core_ld), '0);
        n   = 0;
        lds = 0;
        while (rsp_valid == '0 && n < int'(TO) + 20) begin
            if (core_ld) lds++;
            if (glitch && n == 2 && !pend[gl]) begin
                req_valid = pend | onehot(gl);
                #1;
            end
            if (glitch && n == 4) drive_req();
            chk("req_ready_busy", 128'(req_ready), '0);
            tick();
            n++;
        end
        eerr = mute || lat > int'(TO);
        elat = eerr ? int'(TO) : lat;
        ert  = eerr ? '0 : cipher(ek, et);
        chk("rsp_latency", 128'(n),         128'(elat));
        chk("extra_ld",    128'(lds),       '0);
        chk("rsp_valid",   128'(rsp_valid), 128'(onehot(g)));
        chk("rsp_text",    rsp_text,        ert);
        chk("rsp_err",     128'(rsp_err),   128'(eerr));
        for (int b = 0; b < bp; b++) begin
            rsp_ready = ~onehot(g);
            tick();
            chk("bp_rsp_valid", 128'(rsp_valid), 128'(onehot(g)));
            chk("bp_rsp_text",  rsp_text,        ert);
            chk("bp_req_ready", 128'(req_ready), '0);
        end
        rsp_ready = onehot(g);
        tick();
        rsp_ready  = '0;
        model_last = g;
        chk("rsp_done_valid", 128'(rsp_valid), '0);
        chk("rsp_done_busy",  128'(busy),      '0);
    endtask

    initial begin
        int acc, prev;
        rst       = 1'b1;
        rsp_ready = '0;
        pend      = '0;
        for (int i = 0; i < N; i++) begin
            mkey[i]  = '0;
            mtext[i] = '0;
        end
        drive_req();
        req_valid = '1;
        repeat (3) tick();
        chk_all_zero("reset");
        req_valid  = '0;
        rst        = 1'b0;
        model_last = N - 1;
        tick();

        // Known-answer single request on requester 0.
        set_req(0, KAT_KEY, KAT_PT);
        serve_one(10, 1'b0, 0, 1'b0, 1'b0, acc);

        // Response backpressure on requester 2.
        new_req(2);
        serve_one(6, 1'b0, 10, 1'b0, 1'b0, acc);

        // Core never answers, then a normal request.
        new_req(1);
        serve_one(5, 1'b1, 0, 1'b0, 1'b0, acc);
        new_req(3);
        serve_one(5, 1'b0, 0, 1'b0, 1'b0, acc);

        // Done exactly on the last allowed cycle, then one cycle too late.
        new_req(0);
        serve_one(int'(TO), 1'b0, 0, 1'b0, 1'b0, acc);
        new_req(1);
        serve_one(int'(TO) + 1, 1'b0, 0, 1'b0, 1'b0, acc);

        // A request raised and dropped while busy must leave no trace.
        new_req(1);
        serve_one(8, 1'b0, 0, 1'b0, 1'b1, acc);
        for (int c = 0; c < 4; c++) begin
            chk("idle_req_ready", 128'(req_ready), '0);
            chk("idle_busy",      128'(busy),      '0);
            chk("idle_core_ld",   128'(core_ld),   '0);
            tick();
        end

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            serve_one(int'($urandom_range(1, 12)), 1'b0, int'($urandom_range(0, 3)),
                      1'b0, 1'b0, acc);
        end
        pend = '0;
        drive_req();
        tick();

        // Reset while waiting on the core; its late done must be ignored.
        new_req(2);
        core_lat  = 30;
        core_mute = 1'b0;
        drive_req();
        for (int c = 0; c < 10 && req_ready == '0; c++) tick();
        chk("mid_accept", 128'(req_ready), 128'(onehot(2)));
        tick();
        pend = '0;
        drive_req();
        repeat (3) tick();
        chk("mid_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) stray = 1'b1;
            if (c == 6) stray = 1'b0;
            tick();
            chk("post_rst_rsp_valid", 128'(rsp_valid), '0);
            chk("post_rst_busy",      128'(busy),      '0);
            chk("post_rst_core_ld",   128'(core_ld),   '0);
        end
        model_last = N - 1;

        // All requesters continuously valid: 0,1,2,3,0 at one grant per lat+3 cycles.
        for (int i = 0; i < N; i++) new_req(i);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            serve_one(3, 1'b0, 0, 1'b1, 1'b0, acc);
            chk("fair_grant", 128'(model_last), 128'(k % N));
            if (k > 0) chk("throughput", 128'(acc - prev), 128'(6));
            prev = acc;
        end
        pend = '0;
        drive_req();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
